adc_trigger_capture: RTL and testbench

//  Downstream stage of the ADS8861 serial reader: consumes its 16-bit sample stream and records one

---
 rtl/adc_trigger_capture_pkg.sv | 21 ++
 rtl/adc_trigger_capture_ram.sv | 32 +++
 rtl/adc_trigger_capture.sv | 164 ++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_trigger_capture_pkg.sv
// Shared types and defaults for the ADC trigger/capture stage.
// Holds the capture FSM state encoding and the default sample/address widths.
package adc_trigger_capture_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned AW_DEF    = 10;
  localparam int unsigned DEPTH_DEF = 2 ** AW_DEF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } cap_state_e;

  function automatic logic state_is_busy(input cap_state_e s);
    return (s == FILL) || (s == WAIT) || (s == POST);
  endfunction

endpackage

// File: rtl/adc_trigger_capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Written for block-RAM inference; the read register holds when re is low.
module adc_trigger_capture_ram
  import adc_trigger_capture_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Single-frame oscilloscope capture: circular pre-trigger history, edge/forced trigger,
// post-trigger fill, then a frozen frame read out in time order.
module adc_trigger_capture
  import adc_trigger_capture_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  input  logic          arm,
  input  logic          trig_fall,
  input  logic [DW-1:0] trig_level,
  input  logic [AW-1:0] pretrig,
  input  logic          force_trig,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  cap_state_e state, state_nxt, eff_state;

  logic [AW-1:0]        wr_ptr, pre_lat, pre_lat_nxt, trig_addr_nxt, pre_clamp, eff_pre;
  logic [CW-1:0]        cnt, cnt_nxt, eff_cnt, post_len;
  logic signed [DW-1:0] prev, cur_s, lvl_s;
  logic                 prev_valid, prev_valid_nxt, eff_pv;
  logic                 force_pend, force_pend_nxt, eff_force;
  logic                 edge_hit, hit;
  logic                 wr_en_c, rd_en_c;
  logic [AW-1:0]        rd_addr_c;

  assign cur_s = $signed(smp_data);
  assign lvl_s = $signed(trig_level);

  // Pretrig is limited so the trigger sample always lands in the post-trigger part.
  assign pre_clamp = (pretrig >= AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : pretrig;

  assign edge_hit = trig_fall ? ((prev > lvl_s) && (cur_s <= lvl_s))
                              : ((prev < lvl_s) && (cur_s >= lvl_s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // An arm pulse restarts the capture in the same cycle, so any coincident
  // sample is processed against the freshly armed context.
  always_comb begin
    eff_state      = state;
    eff_cnt        = cnt;
    eff_pre        = pre_lat;
    eff_pv         = prev_valid;
    eff_force      = force_pend;
    if (arm) begin
      eff_state = (pre_clamp != '0) ? FILL : WAIT;
      eff_cnt   = '0;
      eff_pre   = pre_clamp;
      eff_pv    = 1'b0;
      eff_force = 1'b0;
    end
    post_len       = CW'(DEPTH) - CW'(eff_pre);
    state_nxt      = eff_state;
    cnt_nxt        = eff_cnt;
    pre_lat_nxt    = eff_pre;
    prev_valid_nxt = eff_pv;
    force_pend_nxt = eff_force;
    trig_addr_nxt  = trig_addr;
    wr_en_c        = 1'b0;
    hit            = 1'b0;
    case (eff_state)
      FILL: begin
        if (smp_valid) begin
          wr_en_c = 1'b1;
          cnt_nxt = eff_cnt + CW'(1);
          if (cnt_nxt == CW'(eff_pre)) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        force_pend_nxt = eff_force | force_trig;
        if (smp_valid) begin
          wr_en_c = 1'b1;
          hit     = force_trig || eff_force || (eff_pv && edge_hit);
          if (hit) begin
            trig_addr_nxt  = wr_ptr;
            force_pend_nxt = 1'b0;
            cnt_nxt        = CW'(1);
            state_nxt      = (post_len == CW'(1)) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (smp_valid) begin
          wr_en_c = 1'b1;
          cnt_nxt = eff_cnt + CW'(1);
          if (cnt_nxt == post_len) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
      end
      default: ;
    endcase
    if (wr_en_c) prev_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_lat    <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
      trig_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= cur_s;
      end
      cnt        <= cnt_nxt;
      pre_lat    <= pre_lat_nxt;
      prev_valid <= prev_valid_nxt;
      force_pend <= force_pend_nxt;
      trig_addr  <= trig_addr_nxt;
      busy       <= state_is_busy(state_nxt);
      done       <= (state_nxt == DONE);
      rd_valid   <= rd_en_c;
    end
  end

  // Logical index 0 is the oldest pre-trigger sample; address math wraps at AW bits.
  assign rd_en_c   = rd_en && (state == DONE);
  assign rd_addr_c = trig_addr - pre_lat + rd_idx;

  adc_trigger_capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_capture_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (smp_data),
    .re    (rd_en_c),
    .raddr (rd_addr_c),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture with a 16-deep frame (AW=4).
module tb_adc_trigger_capture;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          arm;
  logic          trig_fall;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] pretrig;
  logic          force_trig;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_trigger_capture #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .arm        (arm),
    .trig_fall  (trig_fall),
    .trig_level (trig_level),
    .pretrig    (pretrig),
    .force_trig (force_trig),
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val);
    smp_valid = 1'b1;
    smp_data  = 16'(val);
    step();
    smp_valid = 1'b0;
  endtask

  task automatic do_arm(input int pre);
    pretrig = 4'(pre);
    arm     = 1'b1;
    step();
    arm     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; smp_valid = 1'b0; smp_data = '0; arm = 1'b0; trig_fall = 1'b0;
    trig_level = '0; pretrig = '0; force_trig = 1'b0; rd_en = 1'b0; rd_idx = '0;
    #12;
    checks++;
    if ({busy, done, trig_addr, rd_data, rd_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b trig_addr=%0d rd_data=%h rd_valid=%b, want all 0",
               busy, done, trig_addr, rd_data, rd_valid);
    end
    rst = 1'b1;
    step();
  endtask

  // Rising trigger on a repeating -8..+7 ramp, then full time-ordered readback.
  task automatic test_rising_ramp();
    logic [DW-1:0] exp;
    trig_fall = 1'b0; trig_level = 16'(0);
    do_arm(4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_after_arm: got %b want 1", busy); end
    for (int k = 0; k < 20; k++) begin
      send((k % 16) - 8);
      if (k == 8) begin
        checks++;
        if (trig_addr !== 4'd8) begin errors++; $display("FAIL t1_trig_addr: got %0d want 8", trig_addr); end
      end
      if (k == 18) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL t1_done_early: got %b want 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_done: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      step();
      exp = 16'(((4 + i) % 16) - 8);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++; $display("FAIL t1_read idx=%0d: got valid=%b data=%0d want valid=1 data=%0d",
                           i, rd_valid, $signed(rd_data), $signed(exp));
      end
    end
    rd_en = 1'b0;
    step();
  endtask

  // Falling trigger on a step 200 -> 50.
  task automatic test_falling_step();
    trig_fall = 1'b1; trig_level = 16'(100);
    do_arm(4);
    for (int k = 0; k < 6; k++) send(200);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t2_no_trigger_on_const: got busy=%b done=%b want 1/0", busy, done);
    end
    send(50);
    checks++;
    if (trig_addr !== 4'd10) begin errors++; $display("FAIL t2_trig_addr: got %0d want 10", trig_addr); end
    for (int k = 0; k < 11; k++) send(50);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b want 1", done); end
    rd_en = 1'b1; rd_idx = 4'd4; step();
    checks++;
    if (rd_data !== 16'(50)) begin errors++; $display("FAIL t2_read_trig: got %0d want 50", rd_data); end
    rd_idx = 4'd3; step();
    checks++;
    if (rd_data !== 16'(200)) begin errors++; $display("FAIL t2_read_pre: got %0d want 200", rd_data); end
    rd_en = 1'b0;
    step();
  endtask

  // No edge on constant input; a lone force_trig pulse triggers on the next sample.
  task automatic test_force();
    trig_fall = 1'b0; trig_level = 16'(0);
    do_arm(6);
    for (int k = 0; k < 9; k++) send(5);
    force_trig = 1'b1; step(); force_trig = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t3_waiting: got busy=%b done=%b want 1/0", busy, done);
    end
    send(7);
    checks++;
    if (trig_addr !== 4'd15) begin errors++; $display("FAIL t3_trig_addr: got %0d want 15", trig_addr); end
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL t3_done_early: got %b want 0", done); end
      end
      send(5);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL t3_done: got %b want 1", done); end
    rd_en = 1'b1; rd_idx = 4'd6; step();
    checks++;
    if (rd_data !== 16'(7)) begin errors++; $display("FAIL t3_read_trig: got %0d want 7", rd_data); end
    rd_en = 1'b0;
    step();
  endtask

  // pretrig=0: WAIT is live right after arm, so a forced first sample triggers.
  task automatic test_pretrig_zero();
    do_arm(0);
    force_trig = 1'b1;
    send(1234);
    force_trig = 1'b0;
    checks++;
    if (trig_addr !== 4'd9 || busy !== 1'b1) begin
      errors++; $display("FAIL t4_trig_addr: got addr=%0d busy=%b want 9/1", trig_addr, busy);
    end
    for (int j = 1; j <= 15; j++) begin
      if (j == 15) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL t4_done_early: got %b want 0", done); end
      end
      send(2000 + j);
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b want 1", done); end
    rd_en = 1'b1; rd_idx = 4'd0; step();
    checks++;
    if (rd_data !== 16'(1234)) begin errors++; $display("FAIL t4_read_idx0: got %0d want 1234", rd_data); end
    rd_idx = 4'd15; step();
    checks++;
    if (rd_data !== 16'(2015)) begin errors++; $display("FAIL t4_read_idx15: got %0d want 2015", rd_data); end
    rd_en = 1'b0;
    step();
  endtask

  // Re-arm during POST discards the old trigger; then async reset mid-capture.
  task automatic test_rearm_and_reset();
    trig_fall = 1'b0; trig_level = 16'(0);
    do_arm(2);
    send(-1); send(-1); send(-1); send(0);
    checks++;
    if (trig_addr !== 4'd12) begin errors++; $display("FAIL t5_trig_addr: got %0d want 12", trig_addr); end
    send(1); send(2); send(3);
    do_arm(2);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t5_rearm: got busy=%b done=%b want 1/0", busy, done);
    end
    for (int k = 0; k < 14; k++) send(3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL t5_no_stale_trigger: got busy=%b done=%b want 1/0", busy, done);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, trig_addr, rd_data, rd_valid} !== '0) begin
      errors++;
      $display("FAIL t5_async_reset: got busy=%b done=%b trig_addr=%0d rd_data=%h rd_valid=%b, want all 0",
               busy, done, trig_addr, rd_data, rd_valid);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  // Arm with a coincident sample, trigger across the address wrap, sustained reads.
  task automatic test_wrap_and_reads();
    logic [DW-1:0] exp_tab [8];
    exp_tab = '{16'(24), 16'(25), 16'(26), 16'(-5), 16'(-6), 16'(-7), 16'(-8), 16'(-9)};
    trig_fall = 1'b1; trig_level = 16'(0);
    pretrig = 4'd3; arm = 1'b1;
    send(10);
    arm = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      send(10 + k);
      if (k == 8) begin
        rd_en = 1'b1; rd_idx = 4'd0; step(); rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL t6_read_while_busy: got %b want 0", rd_valid); end
      end
    end
    send(-5);
    checks++;
    if (trig_addr !== 4'd1) begin errors++; $display("FAIL t6_trig_addr: got %0d want 1", trig_addr); end
    for (int j = 0; j < 12; j++) send(-6 - j);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL t6_done: got %b want 1", done); end
    rd_en = 1'b1;
    rd_idx = 4'd0;
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL t6_valid_latency: got %b want 0", rd_valid); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 4'(i);
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_tab[i]) begin
        errors++; $display("FAIL t6_read idx=%0d: got valid=%b data=%0d want valid=1 data=%0d",
                           i, rd_valid, $signed(rd_data), $signed(exp_tab[i]));
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'(-9)) begin
      errors++; $display("FAIL t6_read_hold: got valid=%b data=%0d want valid=0 data=-9",
                         rd_valid, $signed(rd_data));
    end
  endtask

  initial begin
    test_reset();
    test_rising_ramp();
    test_falling_step();
    test_force();
    test_pretrig_zero();
    test_rearm_and_reset();
    test_wrap_and_reads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
